// File: rtl/fxp_to_lns.sv
// Converts signed Q8.8 fixed point to a 12-bit LNS word {sign, log2|x| as Q4.7}.
// Latency: 8 cycles from the accept edge to out_valid. One conversion is in flight at a time.
// Backpressure: in_ready is high only in IDLE. DONE holds out_data until out_ready is seen.
//
// Ports:
//   clk, rst             single clock; synchronous active-high reset
//   in_data/valid/ready  Q8.8 operand, valid/ready handshake
//   out_data/valid/ready LNS result {sgn, log[10:0]}; zero encodes as 12'h400
module fxp_to_lns (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [11:0] LNS_ZERO = 12'h400;

  state_e      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic        zero_q, zero_d;
  logic [15:0] mag_q, mag_d;     // |operand|, unsigned, so 16'h8000 is 32768
  logic [15:0] m_q, m_d;         // normalised mantissa, 1.15, m[15] set after NORM
  logic [3:0]  p_q, p_d;         // integer part of log2 before bias removal
  logic [6:0]  frac_q, frac_d;   // fraction bits, filled MSB first
  logic [2:0]  cnt_q, cnt_d;     // iteration index 0..6
  logic [11:0] out_q, out_d;

  // Leading-one position of the magnitude. A zero operand gives 0, which is
  // harmless because the zero flag overrides the result.
  logic [3:0] lead;
  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (mag_q[i]) lead = 4'(i);
    end
  end

  // Square of a 1.15 mantissa is a 2.30 value. Only bits [31:15] matter:
  // bit 16 of this slice says the square reached 2.0, which yields a fraction
  // bit of 1 and a renormalising shift right by one.
  logic [16:0] sq_top;
  assign sq_top = 17'(({16'h0, m_q} * {16'h0, m_q}) >> 15);

  logic [6:0] frac_nxt;
  assign frac_nxt = sq_top[16] ? (frac_q | (7'h40 >> cnt_q)) : frac_q;

  // Subtracting the Q8.8 bias of 8 from the 4-bit exponent; wraps into a
  // signed -8..+7 integer part.
  logic [3:0] exp_w;
  assign exp_w = p_q - 4'd8;

  // 11'h400 (-8.0) would collide with the zero code; it only arises for
  // mag == 1, so nudge it up by one LSB.
  logic [10:0] log_raw, log_sat;
  logic [11:0] result;
  always_comb begin
    log_raw = {exp_w, frac_nxt};
    log_sat = (log_raw == 11'h400) ? 11'h401 : log_raw;
    result  = zero_q ? LNS_ZERO : {sgn_q, log_sat};
  end

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    m_d     = m_q;
    p_d     = p_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sgn_d   = in_data[15];
          mag_d   = in_data[15] ? (~in_data + 16'd1) : in_data;
          zero_d  = (in_data == 16'd0);
          state_d = NORM;
        end
      end
      NORM: begin
        p_d     = lead;
        m_d     = mag_q << (4'd15 - lead);
        frac_d  = 7'd0;
        cnt_d   = 3'd0;
        state_d = ITER;
      end
      ITER: begin
        m_d    = sq_top[16] ? sq_top[16:1] : sq_top[15:0];
        frac_d = frac_nxt;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          // Result is registered on the last iteration edge so out_valid
          // and out_data appear together.
          out_d   = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= 16'd0;
      m_q     <= 16'd0;
      p_q     <= 4'd0;
      frac_q  <= 7'd0;
      cnt_q   <= 3'd0;
      out_q   <= LNS_ZERO;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      m_q     <= m_d;
      p_q     <= p_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

endmodule
